// File: rtl/gate_resp_checker.sv
// Gate response checker: runs a fixed number of (a, b, y) samples against a
// selected 2-input gate and counts the mismatches.
// Optional feature macro: GATE_CHK_FIRSTFAIL_EN adds first-mismatch capture
// (o_first_fail_idx, o_first_fail_ab).
module gate_resp_checker #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [CNT_W-1:0] i_n_vec,
    input  logic             i_in_valid,
    input  logic             i_a,
    input  logic             i_b,
    input  logic             i_y,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [CNT_W-1:0] o_vec_cnt,
    output logic [CNT_W-1:0] o_err_cnt
`ifdef GATE_CHK_FIRSTFAIL_EN
    ,
    output logic [CNT_W-1:0] o_first_fail_idx,
    output logic [1:0]       o_first_fail_ab
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic [CNT_W-1:0] ErrMax = '1;

    state_e           r_state, w_state_nxt;
    logic [1:0]       r_op, w_op_nxt;
    logic [CNT_W-1:0] r_n_vec, w_n_vec_nxt;
    logic [CNT_W-1:0] r_vec_cnt, w_vec_cnt_nxt;
    logic [CNT_W-1:0] r_err_cnt, w_err_cnt_nxt;
    logic [CNT_W-1:0] w_vec_inc;
    logic             w_exp;
    logic             w_mismatch;
`ifdef GATE_CHK_FIRSTFAIL_EN
    logic [CNT_W-1:0] r_ff_idx, w_ff_idx_nxt;
    logic [1:0]       r_ff_ab, w_ff_ab_nxt;
`endif

    // Expected gate output for the op latched at run start
    always_comb begin
        w_exp = 1'b0;
        unique case (r_op)
            2'b00:   w_exp = i_a & i_b;
            2'b01:   w_exp = i_a | i_b;
            2'b10:   w_exp = i_a ^ i_b;
            2'b11:   w_exp = ~(i_a & i_b);
            default: w_exp = 1'b0;
        endcase
    end

    assign w_mismatch = (i_y != w_exp);

    // Next-state and counter update
    always_comb begin
        w_state_nxt   = r_state;
        w_op_nxt      = r_op;
        w_n_vec_nxt   = r_n_vec;
        w_vec_cnt_nxt = r_vec_cnt;
        w_err_cnt_nxt = r_err_cnt;
        w_vec_inc     = r_vec_cnt + 1'b1;
`ifdef GATE_CHK_FIRSTFAIL_EN
        w_ff_idx_nxt  = r_ff_idx;
        w_ff_ab_nxt   = r_ff_ab;
`endif
        unique case (r_state)
            StIdle, StDone: begin
                if (i_start) begin
                    w_op_nxt      = i_op;
                    w_n_vec_nxt   = i_n_vec;
                    w_vec_cnt_nxt = '0;
                    w_err_cnt_nxt = '0;
`ifdef GATE_CHK_FIRSTFAIL_EN
                    w_ff_idx_nxt  = '0;
                    w_ff_ab_nxt   = '0;
`endif
                    // An empty run completes immediately and trivially passes
                    w_state_nxt   = (i_n_vec == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (i_in_valid) begin
                    w_vec_cnt_nxt = w_vec_inc;
                    if (w_mismatch) begin
                        if (r_err_cnt != ErrMax) begin
                            w_err_cnt_nxt = r_err_cnt + 1'b1;
                        end
`ifdef GATE_CHK_FIRSTFAIL_EN
                        // No earlier mismatch in this run means this is the first one
                        if (r_err_cnt == '0) begin
                            w_ff_idx_nxt = r_vec_cnt;
                            w_ff_ab_nxt  = {i_a, i_b};
                        end
`endif
                    end
                    if (w_vec_inc == r_n_vec) begin
                        w_state_nxt = StDone;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // State and counter registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_op      <= 2'b00;
            r_n_vec   <= '0;
            r_vec_cnt <= '0;
            r_err_cnt <= '0;
`ifdef GATE_CHK_FIRSTFAIL_EN
            r_ff_idx  <= '0;
            r_ff_ab   <= 2'b00;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_op      <= w_op_nxt;
            r_n_vec   <= w_n_vec_nxt;
            r_vec_cnt <= w_vec_cnt_nxt;
            r_err_cnt <= w_err_cnt_nxt;
`ifdef GATE_CHK_FIRSTFAIL_EN
            r_ff_idx  <= w_ff_idx_nxt;
            r_ff_ab   <= w_ff_ab_nxt;
`endif
        end
    end

    assign o_busy    = (r_state == StRun);
    assign o_done    = (r_state == StDone);
    assign o_pass    = (r_state == StDone) && (r_err_cnt == '0);
    assign o_vec_cnt = r_vec_cnt;
    assign o_err_cnt = r_err_cnt;
`ifdef GATE_CHK_FIRSTFAIL_EN
    assign o_first_fail_idx = r_ff_idx;
    assign o_first_fail_ab  = r_ff_ab;
`endif

endmodule

// File: doc/gate_resp_checker.md
GATE_RESP_CHECKER -- requirements
Module: gate_resp_checker

Interface
REQ-001 Parameter CNT_W, default 4: width of vector-count, error-count and index fields.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 start  input  1  one-cycle pulse that begins a check run.
REQ-005 op  input  2  gate under test: 00 AND, 01 OR, 10 XOR, 11 NAND; latched on an accepted start.
REQ-006 n_vec  input  CNT_W  number of vectors in the run; latched on an accepted start.
REQ-007 in_valid  input  1  a, b, y form a valid sample this cycle.
REQ-008 a, b  input  1 each  stimulus applied to the gate.
REQ-009 y  input  1  gate response.
REQ-010 busy  output  1  high in RUN.
REQ-011 done  output  1  high in DONE.
REQ-012 pass  output  1  done AND err_cnt==0.
REQ-013 vec_cnt  output  CNT_W  valid samples accepted in the current run.
REQ-014 err_cnt  output  CNT_W  mismatching samples in the current run; saturating.
REQ-015 first_fail_idx  output  CNT_W  vec_cnt value of the first mismatch (present only with GATE_CHK_FIRSTFAIL_EN).
REQ-016 first_fail_ab  output  2  {a,b} of the first mismatch (present only with GATE_CHK_FIRSTFAIL_EN).

Function
REQ-017 FSM states: IDLE, RUN, DONE; encoding is implementation-defined.
REQ-018 IDLE, start=1, n_vec!=0 -> latch op and n_vec, clear counters, enter RUN on the next edge.
REQ-019 IDLE, start=1, n_vec==0 -> enter DONE directly, with pass=1 and all counters 0.
REQ-020 Expected value: exp = a&b, a|b, a^b or ~(a&b), selected by the latched op.
REQ-021 RUN, in_valid=1 -> vec_cnt+1 and, if y!=exp, err_cnt+1; both visible one cycle after the sample edge.
REQ-022 RUN, in_valid=0 -> counters hold; gaps of any length are allowed.
REQ-023 RUN -> DONE on the edge that accepts the sample that makes vec_cnt equal the latched n_vec.
REQ-024 in_valid outside RUN is ignored; start in RUN is ignored; changes to op or n_vec during RUN have no effect.
REQ-025 DONE holds done, pass and all counters until the next start.
REQ-026 start in DONE behaves as start in IDLE (REQ-018/019), so runs can be issued back to back.
REQ-027 err_cnt saturates at all-ones and never wraps.
REQ-028 Outputs are registered; there is no combinational path from inputs to outputs.

Reset
REQ-029 With rst_n=0 at a clock edge: state = IDLE; busy, done and pass = 0; vec_cnt, err_cnt, first_fail_idx and first_fail_ab = 0.
REQ-030 Reset asserted mid-RUN aborts the run without reaching DONE; the first start after release begins a clean run.
REQ-031 Reset has priority over start and in_valid in the same cycle.

Configuration
REQ-032 Macro GATE_CHK_FIRSTFAIL_EN defined: first_fail_idx and first_fail_ab exist.
- Both capture the first mismatch of a run; later mismatches do not overwrite them.
- Both clear on an accepted start and on reset.
- first_fail_idx = vec_cnt before the increment (0-based sample index).
REQ-033 Macro GATE_CHK_FIRSTFAIL_EN undefined: both ports and their registers are absent; all other behaviour is identical.

Verification
REQ-034 op=00, n_vec=4; samples (0,0,0), (0,1,0), (1,0,0), (1,1,1), one per clock -> done=1, pass=1, vec_cnt=4, err_cnt=0, busy low in the cycle done rises.
REQ-035 op=00, n_vec=4; sample 1 is (0,1,y=1), the rest correct -> err_cnt=1, pass=0, first_fail_idx=1, first_fail_ab=01 (macro on).
REQ-036 op=10, n_vec=4; in_valid high every other cycle, with start pulses and changes to op in the gaps -> same result as contiguous samples; start and op changes ignored.
REQ-037 start with n_vec=0 -> done=1 and pass=1 after one cycle, with busy never high.
REQ-038 op=11, n_vec=15; all 15 samples wrong -> err_cnt=15 with no wrap; then start with n_vec=2 and correct samples -> err_cnt=0, pass=1.
REQ-039 rst_n=0 for one cycle after 2 of 4 samples -> all outputs 0, state IDLE; a further in_valid does nothing until start.
